// File: rtl/color_sequencer.sv
// RGB color sequencer: holds each of six colors, then fades the three duty values toward the next one.
// Optional macro COLOR_SEQ_REVERSE_EN adds a dir input that lets the color order run backwards.
module color_sequencer #(
   parameter int PWM_INTERVAL  = 1200,
   parameter int STEP_INTERVAL = 5000,
   parameter int FADE_INC      = 40,
   parameter int HOLD_STEPS    = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        skip,
`ifdef COLOR_SEQ_REVERSE_EN
   input  logic        dir,
`endif
   output logic [10:0] r_val,
   output logic [10:0] g_val,
   output logic [10:0] b_val,
   output logic [2:0]  color_idx,
   output logic        fading,
   output logic        wrap
);

   localparam int TCW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
   localparam int HCW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [TCW-1:0] TICK_LAST = TCW'(STEP_INTERVAL - 1);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_STEPS - 1);
   localparam logic [10:0]    FULL      = 11'(PWM_INTERVAL);
   localparam logic [10:0]    INC       = 11'(FADE_INC);
   localparam logic [2:0]     LAST_IDX  = 3'd5;

   typedef enum logic {HOLD, FADE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     idx_q, idx_d;
   logic [HCW-1:0] hold_q, hold_d;
   logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
   logic [10:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic           wrap_q, wrap_d;

   logic           tick;
   logic           rev;
   logic [2:0]     next_idx;
   logic           at_wrap;
   logic [2:0]     mask;
   logic [10:0]    tr, tg, tb;

   // Bit 2 = red, bit 1 = green, bit 0 = blue; each lit channel targets full scale.
   function automatic logic [2:0] color_mask(input logic [2:0] idx);
      case (idx)
         3'd0:    color_mask = 3'b100;
         3'd1:    color_mask = 3'b110;
         3'd2:    color_mask = 3'b010;
         3'd3:    color_mask = 3'b011;
         3'd4:    color_mask = 3'b001;
         3'd5:    color_mask = 3'b101;
         default: color_mask = 3'b100;
      endcase
   endfunction

   // Moves v one increment toward t, landing exactly on t rather than overshooting it.
   function automatic logic [10:0] step_toward(input logic [10:0] v, input logic [10:0] t);
      logic [10:0] diff;
      diff = '0;
      if (v < t) begin
         diff        = t - v;
         step_toward = (diff <= INC) ? t : v + INC;
      end else if (v > t) begin
         diff        = v - t;
         step_toward = (diff <= INC) ? t : v - INC;
      end else begin
         step_toward = v;
      end
   endfunction

`ifdef COLOR_SEQ_REVERSE_EN
   assign rev = dir;
`else
   assign rev = 1'b0;
`endif

   always_comb begin
      next_idx = '0;
      at_wrap  = 1'b0;
      if (rev) begin
         at_wrap  = (idx_q == 3'd0);
         next_idx = at_wrap ? LAST_IDX : idx_q - 3'd1;
      end else begin
         at_wrap  = (idx_q == LAST_IDX);
         next_idx = at_wrap ? 3'd0 : idx_q + 3'd1;
      end
   end

   assign mask = color_mask(idx_q);
   assign tr   = mask[2] ? FULL : 11'd0;
   assign tg   = mask[1] ? FULL : 11'd0;
   assign tb   = mask[0] ? FULL : 11'd0;
   assign tick = run && (tick_cnt_q == TICK_LAST);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      tick_cnt_d = tick_cnt_q;
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
      wrap_d     = 1'b0;

      if (run) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
      end

      // A skip wins over a coincident tick, so the duties are left alone on that edge.
      if (skip) begin
         idx_d   = next_idx;
         wrap_d  = at_wrap;
         state_d = FADE;
         hold_d  = '0;
      end else if (tick) begin
         case (state_q)
            HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  idx_d   = next_idx;
                  wrap_d  = at_wrap;
                  state_d = FADE;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HCW'(1);
               end
            end
            FADE: begin
               r_d = step_toward(r_q, tr);
               g_d = step_toward(g_q, tg);
               b_d = step_toward(b_q, tb);
               if (r_d == tr && g_d == tg && b_d == tb) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end
            end
            default: state_d = HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HOLD;
         idx_q      <= '0;
         hold_q     <= '0;
         tick_cnt_q <= '0;
         r_q        <= FULL;
         g_q        <= '0;
         b_q        <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         tick_cnt_q <= tick_cnt_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         wrap_q     <= wrap_d;
      end
   end

   assign r_val     = r_q;
   assign g_val     = g_q;
   assign b_val     = b_q;
   assign color_idx = idx_q;
   assign fading    = (state_q == FADE);
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: a vector table for the full color cycle plus
// hand-written sequences for skip, pause, skip-on-tick and mid-fade reset.
module tb_color_sequencer;
   localparam int P  = 1200;
   localparam int SI = 4;
   localparam int HS = 2;
   localparam int FI = 500;
   localparam int EW = 38;

   logic        clk = 1'b0;
   logic        rst, run, skip;
`ifdef COLOR_SEQ_REVERSE_EN
   logic        dir;
`endif
   logic [10:0] r_val, g_val, b_val;
   logic [2:0]  color_idx;
   logic        fading, wrap;

   color_sequencer #(
      .PWM_INTERVAL (P),
      .STEP_INTERVAL(SI),
      .FADE_INC     (FI),
      .HOLD_STEPS   (HS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .skip     (skip),
`ifdef COLOR_SEQ_REVERSE_EN
      .dir      (dir),
`endif
      .r_val    (r_val),
      .g_val    (g_val),
      .b_val    (b_val),
      .color_idx(color_idx),
      .fading   (fading),
      .wrap     (wrap)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   typedef struct {
      logic        rst;
      logic        run;
      logic        skip;
      int          edges;
      logic [10:0] r;
      logic [10:0] g;
      logic [10:0] b;
      logic [2:0]  idx;
      logic        fad;
      logic        wr;
   } vec_t;

   vec_t            vecs[$];
   logic [EW-1:0]   exp_q[$];
   int              checks = 0;
   int              passes = 0;

   // driver tasks
   task automatic drive(input logic r, input logic rn, input logic sk);
      rst  = r;
      run  = rn;
      skip = sk;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      drive(1'b1, 1'b0, 1'b0);
      step(2);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   // scoreboard
   task automatic chk_field(input string name, input string field, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
   endtask

   task automatic expect_out(input string name, input int r, input int g, input int b,
                             input int idx, input logic fad, input logic wr);
      logic [EW-1:0] e;
      exp_q.push_back({11'(r), 11'(g), 11'(b), 3'(idx), fad, wr});
      e = exp_q.pop_front();
      chk_field(name, "r_val",     int'(r_val),     int'(e[37:27]));
      chk_field(name, "g_val",     int'(g_val),     int'(e[26:16]));
      chk_field(name, "b_val",     int'(b_val),     int'(e[15:5]));
      chk_field(name, "color_idx", int'(color_idx), int'(e[4:2]));
      chk_field(name, "fading",    int'(fading),    int'(e[1]));
      chk_field(name, "wrap",      int'(wrap),      int'(e[0]));
   endtask

   initial begin
`ifdef COLOR_SEQ_REVERSE_EN
      dir = 1'b0;
`endif
      drive(1'b1, 1'b0, 1'b0);

      // Full forward cycle from reset; ticks land on every 4th edge with run high.
      //              rst run skp edges   r     g     b   idx fad wr
      vecs.push_back('{1'b1, 1'b0, 1'b0,  2,  P,    0,    0,  0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  7,  P,    0,    0,  0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  1,  P,    0,    0,  1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  4,  P,  500,    0,  1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  4,  P, 1000,    0,  1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  4,  P,    P,    0,  1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  8,  P,    P,    0,  2, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  4, 700,   P,    0,  2, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  8,  0,    P,    0,  2, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  8,  0,    P,    0,  3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 12,  0,    P,    P,  3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  8,  0,    P,    P,  4, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 12,  0,    0,    P,  4, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  8,  0,    0,    P,  5, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 12,  P,    0,    P,  5, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  7,  P,    0,    P,  5, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  1,  P,    0,    P,  0, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0,  1,  P,    0,    P,  0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 11,  P,    0,    0,  0, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].run, vecs[i].skip);
         step(vecs[i].edges);
         expect_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b,
                    vecs[i].idx, vecs[i].fad, vecs[i].wr);
      end

      // Skip mid-fade toward yellow at g=500: retarget green, duties carry on.
      apply_reset();
      drive(1'b0, 1'b1, 1'b0);
      step(12);
      expect_out("skip_pre", P, 500, 0, 1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1);
      step(1);
      drive(1'b0, 1'b1, 1'b0);
      expect_out("skip_edge", P, 500, 0, 2, 1'b1, 1'b0);
      step(3);
      expect_out("skip_t1", 700, 1000, 0, 2, 1'b1, 1'b0);
      step(4);
      expect_out("skip_t2", 200, P, 0, 2, 1'b1, 1'b0);
      step(4);
      expect_out("skip_t3", 0, P, 0, 2, 1'b0, 1'b0);

      // Skip on the same edge as a fade tick: no duty change on that edge.
      apply_reset();
      drive(1'b0, 1'b1, 1'b0);
      step(11);
      drive(1'b0, 1'b1, 1'b1);
      step(1);
      drive(1'b0, 1'b1, 1'b0);
      expect_out("skip_tick", P, 0, 0, 2, 1'b1, 1'b0);
      step(4);
      expect_out("skip_tick_next", 700, 500, 0, 2, 1'b1, 1'b0);

      // Pause mid-fade; skip still advances; tick counter resumes where it stopped.
      apply_reset();
      drive(1'b0, 1'b1, 1'b0);
      step(14);
      drive(1'b0, 1'b0, 1'b0);
      step(50);
      expect_out("pause_hold", P, 500, 0, 1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      step(1);
      drive(1'b0, 1'b0, 1'b0);
      step(49);
      expect_out("pause_skip", P, 500, 0, 2, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      step(1);
      expect_out("pause_resume1", P, 500, 0, 2, 1'b1, 1'b0);
      step(1);
      expect_out("pause_resume2", 700, 1000, 0, 2, 1'b1, 1'b0);

      // Reset mid-fade with run and skip both high.
      apply_reset();
      drive(1'b0, 1'b1, 1'b0);
      step(16);
      expect_out("rst_pre", P, 1000, 0, 1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      step(1);
      expect_out("rst_mid", P, 0, 0, 0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      step(7);
      expect_out("rst_after7", P, 0, 0, 0, 1'b0, 1'b0);
      step(1);
      expect_out("rst_after8", P, 0, 0, 1, 1'b1, 1'b0);

`ifdef COLOR_SEQ_REVERSE_EN
      // Reverse direction: first advance from red wraps to magenta.
      apply_reset();
      dir = 1'b1;
      drive(1'b0, 1'b1, 1'b0);
      step(8);
      expect_out("rev_wrap", P, 0, 0, 5, 1'b1, 1'b1);
      step(1);
      expect_out("rev_wrap_end", P, 0, 0, 5, 1'b1, 1'b0);
      dir = 1'b0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
